// File: rtl/combo_if.sv
// Handshake bundle between the combination generator and the combination checker.
interface combo_if;
    logic       enable;
    logic       new_code;
    logic       pass_flag;
    logic [2:0] joy_state;
    logic [2:0] num_1;
    logic [2:0] num_2;
    logic [2:0] num_3;
    logic [2:0] num_4;
    logic       code_valid;
    logic       busy;
    logic [2:0] hint_digit;
    logic [1:0] hint_quadrant;
    logic       hint_show;
    logic [7:0] solved_count;

    modport master (
        output enable, new_code, pass_flag, joy_state,
        input  num_1, num_2, num_3, num_4, code_valid, busy,
               hint_digit, hint_quadrant, hint_show, solved_count
    );

    modport slave (
        input  enable, new_code, pass_flag, joy_state,
        output num_1, num_2, num_3, num_4, code_valid, busy,
               hint_digit, hint_quadrant, hint_show, solved_count
    );
endinterface

// File: rtl/combo_gen.sv
// Generates a 4-digit combination from a free-running LFSR (no two adjacent digits
// equal), counts solves and drives a blinking hint of the digit the checker expects.
module combo_gen #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int unsigned HINT_CYCLES = 25_000_000
) (
    input  logic    clk,
    input  logic    reset,
    combo_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        READY  = 2'd2,
        SOLVED = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_INIT  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [25:0] BLINK_LAST = 26'(HINT_CYCLES - 32'd1);

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [2:0]  digit_q [4];
    logic [1:0]  idx_q;
    logic        pass_q;
    logic [7:0]  solved_q;
    logic [25:0] blink_q;
    logic        show_q;
    logic        busy_q;
    logic        valid_q;

    logic [2:0]  cand;
    logic [2:0]  prev;
    logic        accept;
    logic        pass_rise;
    logic [2:0]  hint;

    // Next LFSR value, digit acceptance, pass_flag edge and hint selection.
    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        cand      = lfsr_q[2:0];
        prev      = digit_q[idx_q - 2'd1];
        accept    = (idx_q == 2'd0) || (cand != prev);
        pass_rise = bus.pass_flag & ~pass_q;
        if ((state_q == READY) && (bus.joy_state < 3'd4)) begin
            hint = digit_q[bus.joy_state[1:0]];
        end else begin
            hint = 3'd0;
        end
    end

    // State machine, digit capture, solve counter and hint blinker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_INIT;
            digit_q  <= '{3'd0, 3'd0, 3'd0, 3'd0};
            idx_q    <= 2'd0;
            pass_q   <= 1'b0;
            solved_q <= 8'd0;
            blink_q  <= 26'd0;
            show_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            pass_q <= bus.pass_flag;
            if (!bus.enable) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                blink_q <= 26'd0;
                show_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        blink_q <= 26'd0;
                        show_q  <= 1'b0;
                        if (bus.new_code) begin
                            state_q <= GEN;
                            idx_q   <= 2'd0;
                            busy_q  <= 1'b1;
                        end
                    end
                    GEN: begin
                        blink_q <= 26'd0;
                        show_q  <= 1'b0;
                        if (accept) begin
                            digit_q[idx_q] <= cand;
                            idx_q          <= idx_q + 2'd1;
                            if (idx_q == 2'd3) begin
                                state_q <= READY;
                                busy_q  <= 1'b0;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    READY: begin
                        // A solve outranks a simultaneous request for a new code.
                        if (pass_rise) begin
                            state_q  <= SOLVED;
                            valid_q  <= 1'b0;
                            solved_q <= (solved_q == 8'd255) ? 8'd255 : solved_q + 8'd1;
                            blink_q  <= 26'd0;
                            show_q   <= 1'b0;
                        end else if (bus.new_code) begin
                            state_q <= GEN;
                            idx_q   <= 2'd0;
                            busy_q  <= 1'b1;
                            valid_q <= 1'b0;
                            blink_q <= 26'd0;
                            show_q  <= 1'b0;
                        end else if (blink_q == BLINK_LAST) begin
                            blink_q <= 26'd0;
                            show_q  <= ~show_q;
                        end else begin
                            blink_q <= blink_q + 26'd1;
                        end
                    end
                    SOLVED: begin
                        state_q <= GEN;
                        idx_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        blink_q <= 26'd0;
                        show_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.num_1         = digit_q[0];
    assign bus.num_2         = digit_q[1];
    assign bus.num_3         = digit_q[2];
    assign bus.num_4         = digit_q[3];
    assign bus.code_valid    = valid_q;
    assign bus.busy          = busy_q;
    assign bus.hint_digit    = hint;
    assign bus.hint_quadrant = hint[1:0];
    assign bus.hint_show     = show_q;
    assign bus.solved_count  = solved_q;
endmodule

// File: tb/tb_combo_gen.sv
// Directed bench for combo_gen: a reference LFSR predicts every generated combination.
module tb_combo_gen;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [15:0] m_lfsr;
    logic [2:0]  e_dig [4];
    logic [2:0]  first_cand;
    int          gen_cycles;
    int          waited;

    combo_if bus ();

    combo_gen #(.HINT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference LFSR, stepped on the same edge as the design.
    always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : nxt(m_lfsr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {8'd0, bus.num_1, bus.num_2, bus.num_3, bus.num_4, bus.code_valid, bus.busy,
                bus.hint_digit, bus.hint_quadrant, bus.hint_show, bus.solved_count};
    endfunction

    // Called in the first GEN cycle: predicts the digits and GEN length, then checks them.
    task automatic gen_run(input string tag);
        logic [15:0] l;
        logic [2:0]  prev;
        int          idx;
        l = m_lfsr;
        prev = 3'd0;
        idx = 0;
        gen_cycles = 0;
        first_cand = l[2:0];
        while (idx < 4) begin
            if ((idx == 0) || (l[2:0] != prev)) begin
                e_dig[idx] = l[2:0];
                prev = l[2:0];
                idx++;
            end
            l = nxt(l);
            gen_cycles++;
        end
        for (int i = 0; i < gen_cycles; i++) begin
            chk({tag, "_busy"}, {30'd0, bus.busy, bus.code_valid}, 32'd2);
            cyc();
        end
        chk({tag, "_ready"}, {30'd0, bus.busy, bus.code_valid}, 32'd1);
        chk({tag, "_digits"}, {20'd0, bus.num_1, bus.num_2, bus.num_3, bus.num_4},
            {20'd0, e_dig[0], e_dig[1], e_dig[2], e_dig[3]});
        chk({tag, "_adjacent"}, {29'd0, bus.num_1 != bus.num_2, bus.num_2 != bus.num_3,
            bus.num_3 != bus.num_4}, 32'd7);
    endtask

    task automatic gen_and_check(input string tag);
        bus.new_code = 1'b1;
        cyc();
        bus.new_code = 1'b0;
        gen_run(tag);
    endtask

    initial begin
        logic [2:0] joy_tab [6];
        logic [2:0] hint_exp;
        int         hold;
        n_vec = 0;
        n_err = 0;
        joy_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

        // Reset with every input high.
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.new_code = 1'b1;
        bus.pass_flag = 1'b1;
        bus.joy_state = 3'd7;
        repeat (3) cyc();
        chk("reset_outputs", all_out(), 32'd0);
        chk("reset_lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);

        reset = 1'b0;
        bus.new_code = 1'b0;
        bus.pass_flag = 1'b0;
        bus.joy_state = 3'd2;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_outputs", all_out(), 32'd0);
        end
        chk("lfsr_track", {16'd0, dut.lfsr_q}, {16'd0, m_lfsr});

        // First combination, then the hint blink with HINT_CYCLES=4.
        gen_and_check("gen1");
        for (int k = 0; k < 12; k++) begin
            chk("blink", {31'd0, bus.hint_show}, ((k / 4) % 2 == 1) ? 32'd1 : 32'd0);
            cyc();
        end

        for (int j = 0; j < 6; j++) begin
            bus.joy_state = joy_tab[j];
            #1;
            hint_exp = (j < 4) ? e_dig[j] : 3'd0;
            chk("hint", {27'd0, bus.hint_digit, bus.hint_quadrant},
                {27'd0, hint_exp, hint_exp[1:0]});
        end

        // new_code in READY restarts generation without counting a solve.
        gen_and_check("regen");
        chk("regen_solved", {24'd0, bus.solved_count}, 32'd0);
        cyc();
        chk("ready_show_clear", {31'd0, bus.hint_show}, 32'd0);

        // pass_flag held high: one solve, one SOLVED cycle, then automatic GEN.
        bus.pass_flag = 1'b1;
        cyc();
        chk("solved_state", {30'd0, bus.busy, bus.code_valid}, 32'd0);
        chk("solved_count1", {24'd0, bus.solved_count}, 32'd1);
        cyc();
        chk("auto_gen_busy", {31'd0, bus.busy}, 32'd1);
        gen_run("autogen");
        for (hold = 2 + gen_cycles; hold < 10; hold++) cyc();
        bus.pass_flag = 1'b0;
        cyc();
        chk("pass_hold_count", {24'd0, bus.solved_count}, 32'd1);
        chk("pass_hold_ready", {31'd0, bus.code_valid}, 32'd1);

        // 256 further solves with new_code raised alongside each pass edge.
        for (int s = 0; s < 256; s++) begin
            bus.pass_flag = 1'b1;
            bus.new_code = 1'b1;
            cyc();
            bus.pass_flag = 1'b0;
            bus.new_code = 1'b0;
            if (s == 0) chk("priority_solved", {30'd0, bus.busy, bus.code_valid}, 32'd0);
            chk("sat_count", {24'd0, bus.solved_count}, (s + 2 > 255) ? 32'd255 : 32'(s + 2));
            waited = 0;
            while (!bus.code_valid && waited < 100) begin
                cyc();
                waited++;
            end
            if (waited >= 100) chk("ready_timeout", 32'(waited), 32'd0);
        end
        chk("sat_final", {24'd0, bus.solved_count}, 32'd255);

        // enable dropped mid-GEN.
        bus.new_code = 1'b1;
        cyc();
        bus.new_code = 1'b0;
        first_cand = m_lfsr[2:0];
        chk("mid_gen_busy", {31'd0, bus.busy}, 32'd1);
        cyc();
        bus.enable = 1'b0;
        bus.new_code = 1'b1;
        cyc();
        chk("abort_idle", {30'd0, bus.busy, bus.code_valid}, 32'd0);
        chk("abort_num1", {29'd0, bus.num_1}, {29'd0, first_cand});
        cyc();
        chk("disabled_ignore", {29'd0, bus.busy, bus.code_valid, bus.hint_show}, 32'd0);

        // Reset asserted mid-GEN.
        bus.enable = 1'b1;
        bus.new_code = 1'b0;
        cyc();
        bus.new_code = 1'b1;
        cyc();
        chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        cyc();
        chk("midgen_reset_out", all_out(), 32'd0);
        chk("midgen_reset_lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);
        reset = 1'b0;
        bus.new_code = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
